ball_collision: RTL and testbench

BALL_COLLISION -- requirements
Module: ball_collision

---
 rtl/ball_pkg.sv | 23 ++
 rtl/box_overlap.sv | 39 +++
 rtl/ball_collision.sv | 144 ++++++++++++++
 tb/tb_ball_collision.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared defaults, FSM state encoding and obstacle record
// for the ball_collision scanner.
package ball_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int NUM_OBS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] w;
    logic [COORD_W_DEF-1:0] h;
    logic                   active;
  } obs_t;

endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational ball-box vs obstacle-box intersection,
// inclusive edges, one bit of headroom so upper edges never wrap.
module box_overlap #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  input  logic [COORD_W-1:0] i_s,
  input  logic [COORD_W-1:0] i_ox,
  input  logic [COORD_W-1:0] i_oy,
  input  logic [COORD_W-1:0] i_ow,
  input  logic [COORD_W-1:0] i_oh,
  input  logic               i_act,
  output logic               o_hit
);

  localparam int EW = COORD_W + 1;

  logic [EW-1:0] w_xlo, w_xhi, w_ylo, w_yhi;
  logic [EW-1:0] w_oxlo, w_oxhi, w_oylo, w_oyhi;
  logic          w_valid, w_xov, w_yov;

  // Ball low edge clamps at 0 instead of wrapping
  assign w_xlo  = (i_cx < i_s) ? '0 : {1'b0, i_cx} - {1'b0, i_s};
  assign w_ylo  = (i_cy < i_s) ? '0 : {1'b0, i_cy} - {1'b0, i_s};
  assign w_xhi  = {1'b0, i_cx} + {1'b0, i_s};
  assign w_yhi  = {1'b0, i_cy} + {1'b0, i_s};

  assign w_oxlo = {1'b0, i_ox};
  assign w_oylo = {1'b0, i_oy};
  assign w_oxhi = {1'b0, i_ox} + {1'b0, i_ow} - EW'(1);
  assign w_oyhi = {1'b0, i_oy} + {1'b0, i_oh} - EW'(1);

  assign w_valid = i_act && (|i_ow) && (|i_oh);
  assign w_xov   = (w_xlo <= w_oxhi) && (w_xhi >= w_oxlo);
  assign w_yov   = (w_ylo <= w_oyhi) && (w_yhi >= w_oylo);
  assign o_hit   = w_valid && w_xov && w_yov;

endmodule

// File: rtl/ball_collision.sv
// ball_collision: per-frame scan of the obstacle table against both balls.
// Define BALL_COLLISION_HIT_COUNT_EN to build the saturating hit counter.
module ball_collision
  import ball_pkg::*;
#(
  parameter int NUM_OBS = NUM_OBS_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic [COORD_W-1:0]         RedX,
  input  logic [COORD_W-1:0]         RedY,
  input  logic [COORD_W-1:0]         BlueX,
  input  logic [COORD_W-1:0]         BlueY,
  input  logic [COORD_W-1:0]         BallS,
  output logic [$clog2(NUM_OBS)-1:0] obs_addr,
  output logic                       obs_rd,
  input  logic [COORD_W-1:0]         obs_x,
  input  logic [COORD_W-1:0]         obs_y,
  input  logic [COORD_W-1:0]         obs_w,
  input  logic [COORD_W-1:0]         obs_h,
  input  logic                       obs_active,
  output logic                       scan_done,
  output logic                       red_hit,
  output logic                       blue_hit,
  output logic                       game_over,
  output logic [7:0]                 hit_count
);

  localparam int AW = $clog2(NUM_OBS);

  state_t             r_state;
  logic [COORD_W-1:0] r_rx, r_ry, r_bx, r_by, r_s;
  logic [AW-1:0]      r_addr;
  logic               r_rd, r_done;
  logic               r_racc, r_bacc;
  logic               r_rhit, r_bhit, r_go;
  logic               w_rhit, w_bhit, w_last;

  box_overlap #(.COORD_W(COORD_W)) u_red (
    .i_cx(r_rx), .i_cy(r_ry), .i_s(r_s),
    .i_ox(obs_x), .i_oy(obs_y),
    .i_ow(obs_w), .i_oh(obs_h),
    .i_act(obs_active), .o_hit(w_rhit)
  );

  box_overlap #(.COORD_W(COORD_W)) u_blue (
    .i_cx(r_bx), .i_cy(r_by), .i_s(r_s),
    .i_ox(obs_x), .i_oy(obs_y),
    .i_ow(obs_w), .i_oh(obs_h),
    .i_act(obs_active), .o_hit(w_bhit)
  );

  assign w_last = (r_addr == AW'(NUM_OBS - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_rx    <= '0;
      r_ry    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_s     <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_done  <= 1'b0;
      r_racc  <= 1'b0;
      r_bacc  <= 1'b0;
      r_rhit  <= 1'b0;
      r_bhit  <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_rx    <= RedX;
            r_ry    <= RedY;
            r_bx    <= BlueX;
            r_by    <= BlueY;
            r_s     <= BallS;
            r_addr  <= '0;
            r_racc  <= 1'b0;
            r_bacc  <= 1'b0;
            r_rd    <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_rd    <= 1'b0;
          r_state <= CHECK;
        end
        CHECK: begin
          r_racc <= r_racc | w_rhit;
          r_bacc <= r_bacc | w_bhit;
          if (w_last) begin
            // Results land with the scan_done pulse
            r_done  <= 1'b1;
            r_rhit  <= r_racc | w_rhit;
            r_bhit  <= r_bacc | w_bhit;
            r_go    <= r_go | r_racc | w_rhit
                            | r_bacc | w_bhit;
            r_state <= DONE;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_rd    <= 1'b1;
            r_state <= FETCH;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BALL_COLLISION_HIT_COUNT_EN
  logic [7:0] r_cnt;
  logic       w_any;

  assign w_any = r_racc | r_bacc | w_rhit | w_bhit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_state == CHECK && w_last && w_any) begin
      r_cnt <= r_cnt + {7'd0, (r_cnt != 8'hFF)};
    end
  end

  assign hit_count = r_cnt;
`else
  assign hit_count = 8'd0;
`endif

  assign obs_addr  = r_addr;
  assign obs_rd    = r_rd;
  assign scan_done = r_done;
  assign red_hit   = r_rhit;
  assign blue_hit  = r_bhit;
  assign game_over = r_go;

endmodule

// File: tb/tb_ball_collision.sv
// tb_ball_collision: randomized and directed checks of ball_collision
// against an arithmetic reference model and a registered obstacle table.
module tb_ball_collision;
  import ball_pkg::*;

  localparam int N  = 8;
  localparam int CW = 10;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_start;
  logic [CW-1:0] RedX, RedY, BlueX, BlueY, BallS;
  logic [2:0]    obs_addr;
  logic          obs_rd;
  logic [CW-1:0] obs_x, obs_y, obs_w, obs_h;
  logic          obs_active;
  logic          scan_done, red_hit, blue_hit, game_over;
  logic [7:0]    hit_count;

  obs_t tbl [N];

  int n_tot = 0;
  int n_bad = 0;
  int exp_go = 0;
  int exp_hc = 0;

  ball_collision #(.NUM_OBS(N), .COORD_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .RedX(RedX), .RedY(RedY), .BlueX(BlueX), .BlueY(BlueY),
    .BallS(BallS), .obs_addr(obs_addr), .obs_rd(obs_rd),
    .obs_x(obs_x), .obs_y(obs_y), .obs_w(obs_w), .obs_h(obs_h),
    .obs_active(obs_active), .scan_done(scan_done),
    .red_hit(red_hit), .blue_hit(blue_hit),
    .game_over(game_over), .hit_count(hit_count)
  );

  always #5 Clk = ~Clk;

  // Obstacle table: read data appears the cycle after the strobe
  always @(posedge Clk) begin
    if (obs_rd) begin
      obs_x      <= tbl[obs_addr].x;
      obs_y      <= tbl[obs_addr].y;
      obs_w      <= tbl[obs_addr].w;
      obs_h      <= tbl[obs_addr].h;
      obs_active <= tbl[obs_addr].active;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic bit ovl(input int cx, input int cy,
                             input int s, input obs_t o);
    int xl, xh, yl, yh, ox1, oy1;
    if (!o.active || o.w == 0 || o.h == 0) return 1'b0;
    xl  = (cx < s) ? 0 : cx - s;
    yl  = (cy < s) ? 0 : cy - s;
    xh  = cx + s;
    yh  = cy + s;
    ox1 = int'(o.x) + int'(o.w) - 1;
    oy1 = int'(o.y) + int'(o.h) - 1;
    return (xl <= ox1) && (xh >= int'(o.x)) &&
           (yl <= oy1) && (yh >= int'(o.y));
  endfunction

  function automatic bit scan_hit(input int cx, input int cy,
                                  input int s);
    bit h = 1'b0;
    for (int i = 0; i < N; i++) h |= ovl(cx, cy, s, tbl[i]);
    return h;
  endfunction

  task automatic model_done(input bit er, input bit eb);
    if (er || eb) begin
      exp_go = 1;
`ifdef BALL_COLLISION_HIT_COUNT_EN
      if (exp_hc < 255) exp_hc++;
`endif
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) tbl[i] = '0;
  endtask

  task automatic set_balls(input int rx, input int ry, input int bx,
                           input int by, input int s);
    RedX  = rx[CW-1:0];
    RedY  = ry[CW-1:0];
    BlueX = bx[CW-1:0];
    BlueY = by[CW-1:0];
    BallS = s[CW-1:0];
  endtask

  task automatic run_scan(input int rx, input int ry, input int bx,
                          input int by, input int s);
    int n;
    bit er, eb;
    er = scan_hit(rx, ry, s);
    eb = scan_hit(bx, by, s);
    @(negedge Clk);
    set_balls(rx, ry, bx, by, s);
    frame_start = 1'b1;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    // Inputs may move during the scan; only the snapshot counts
    set_balls($urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023));
    n = 1;
    while (!scan_done && n < 60) begin
      @(posedge Clk);
      #1;
      n++;
    end
    model_done(er, eb);
    chk("done_cyc", n, 17);
    chk("red_hit", red_hit, er);
    chk("blue_hit", blue_hit, eb);
    chk("game_over", game_over, exp_go);
    chk("hit_count", hit_count, exp_hc);
    @(posedge Clk);
    #1;
    chk("done_pulse", scan_done, 0);
    chk("red_hold", red_hit, er);
  endtask

  initial begin
    int np, pc;
    bit er, eb;
    Reset = 1'b1;
    frame_start = 1'b1;
    set_balls(0, 0, 0, 0, 0);
    clear_tbl();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_done", scan_done, 0);
    chk("rst_red", red_hit, 0);
    chk("rst_blue", blue_hit, 0);
    chk("rst_go", game_over, 0);
    chk("rst_hc", hit_count, 0);
    chk("rst_rd", obs_rd, 0);
    chk("rst_addr", obs_addr, 0);
    @(negedge Clk);
    Reset = 1'b0;
    frame_start = 1'b0;
    np = 0;
    repeat (25) begin
      @(posedge Clk);
      #1;
      if (scan_done) np++;
    end
    chk("no_queue", np, 0);

    // Single active slot overlapping red
    tbl[3] = '{x:10'd402, y:10'd230, w:10'd10, h:10'd8, active:1'b1};
    run_scan(400, 240, 100, 100, 4);
    chk("r040_red", red_hit, 1);
    chk("r040_blue", blue_hit, 0);
    chk("r040_go", game_over, 1);

    // Right edge 404 misses 405, touches 404
    clear_tbl();
    tbl[0] = '{x:10'd405, y:10'd236, w:10'd5, h:10'd5, active:1'b1};
    run_scan(400, 240, 100, 100, 4);
    chk("edge_miss", red_hit, 0);
    tbl[0].x = 10'd404;
    run_scan(400, 240, 100, 100, 4);
    chk("edge_hit", red_hit, 1);

    // Saturated low edge, then inactive slot
    clear_tbl();
    tbl[5] = '{x:10'd0, y:10'd238, w:10'd1, h:10'd1, active:1'b1};
    run_scan(400, 100, 2, 240, 4);
    chk("sat_hit", blue_hit, 1);
    tbl[5].active = 1'b0;
    run_scan(400, 100, 2, 240, 4);
    chk("inact_miss", blue_hit, 0);

    // Second frame_start mid-scan is ignored
    tbl[5].active = 1'b1;
    er = scan_hit(400, 100, 4);
    eb = scan_hit(2, 240, 4);
    np = 0;
    pc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      set_balls(400, 100, 2, 240, 4);
      frame_start = (c == 0 || c == 6);
      @(posedge Clk);
      #1;
      if (scan_done) begin
        np++;
        pc = c + 1;
      end
    end
    frame_start = 1'b0;
    model_done(er, eb);
    chk("dbl_cnt", np, 1);
    chk("dbl_cyc", pc, 17);
    chk("dbl_blue", blue_hit, eb);

    // Randomized tables and balls, some near the top of range
    for (int t = 0; t < 40; t++) begin
      int b;
      b = ($urandom_range(0, 3) == 0) ? 960 : 0;
      for (int i = 0; i < N; i++) begin
        tbl[i].x      = CW'(b + $urandom_range(0, 60));
        tbl[i].y      = CW'(b + $urandom_range(0, 60));
        tbl[i].w      = CW'($urandom_range(0, 6));
        tbl[i].h      = CW'($urandom_range(0, 6));
        tbl[i].active = ($urandom_range(0, 3) != 0);
      end
      run_scan(b + $urandom_range(0, 63), b + $urandom_range(0, 63),
               b + $urandom_range(0, 63), b + $urandom_range(0, 63),
               $urandom_range(0, 8));
    end

    // Many hit frames exercise counter saturation
    clear_tbl();
    tbl[7] = '{x:10'd400, y:10'd236, w:10'd4, h:10'd4, active:1'b1};
    for (int t = 0; t < 300; t++) run_scan(400, 240, 50, 50, 4);
`ifdef BALL_COLLISION_HIT_COUNT_EN
    chk("hc_sat", hit_count, 255);
`else
    chk("hc_off", hit_count, 0);
`endif

    // Reset mid-scan aborts without a pulse
    np = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      frame_start = (c == 0);
      Reset = (c == 9);
      @(posedge Clk);
      #1;
      if (scan_done) np++;
    end
    frame_start = 1'b0;
    Reset = 1'b0;
    exp_go = 0;
    exp_hc = 0;
    chk("abort_done", np, 0);
    chk("abort_red", red_hit, 0);
    chk("abort_blue", blue_hit, 0);
    chk("abort_go", game_over, exp_go);
    chk("abort_hc", hit_count, exp_hc);
    chk("abort_rd", obs_rd, 0);
    chk("abort_addr", obs_addr, 0);
    run_scan(400, 240, 50, 50, 4);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
